// File: rtl/mem_access_unit_pkg.sv
// Shared control encodings for the multicycle datapath: controller states,
// MIPS load/store opcodes and memory-access FSM states.
package mem_access_unit_pkg;

    localparam logic [3:0] STATE_FETCH  = 4'd0;
    localparam logic [3:0] STATE_DECODE = 4'd1;
    localparam logic [3:0] STATE_MEMADR = 4'd2;
    localparam logic [3:0] STATE_MEMRD  = 4'd3;
    localparam logic [3:0] STATE_MEMWB  = 4'd4;
    localparam logic [3:0] STATE_MEMWR  = 4'd5;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_DONE = 2'd2,
        MAU_ERR  = 2'd3
    } mau_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (op inside {OP_LH, OP_LHU, OP_SH}) bad = lo[0];
        if (op inside {OP_LW, OP_SW})         bad = (lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane steering for loads and stores: byte enables, store replication
// and load extraction with sign/zero extension.
module ls_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic [15:0] half_sel;

    assign shifted  = rdata_word_i >> {addr_lo_i, 3'b000};
    assign half_sel = addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_word_i;
        case (op_i)
            OP_LB:  begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            OP_LBU: begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {24'h0, shifted[7:0]};
            end
            OP_LH:  begin
                be_o    = 4'b0011 << addr_lo_i;
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                be_o    = 4'b0011 << addr_lo_i;
                rdata_o = {16'h0, half_sel};
            end
            OP_LW:  be_o = 4'b1111;
            OP_SB:  begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            OP_SH:  begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            OP_SW:  be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-phase load/store engine: launches one memory access per start pulse,
// waits for ack with a timeout, and reports done/err.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | mem_req asserted, waiting for mem_ack
//   DONE  | one-cycle done pulse, err=0
//   ERR   | one-cycle done pulse, err=1 (misaligned, illegal op, timeout)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q;
    logic [31:0]      addr_q, wdata_q, rdata_q, rdata_d;
    logic [31:0]      load_ext;
    logic             accept;

    assign accept = (state_q == MAU_IDLE) && start;

    ls_lane_align u_lane (
        .op_i         (op_q),
        .addr_lo_i    (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rdata_word_i (mem_rdata),
        .be_o         (mem_be),
        .wdata_o      (mem_wdata),
        .rdata_o      (load_ext)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= MAU_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            MAU_IDLE: begin
                if (start) begin
                    if (!(is_load(op) || is_store(op)) || misaligned(op, addr[1:0]))
                        state_d = MAU_ERR;
                    else
                        state_d = MAU_REQ;
                end
            end
            MAU_REQ: begin
                if (mem_ack) begin
                    state_d = MAU_DONE;
                    if (is_load(op_q)) rdata_d = load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = MAU_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MAU_DONE: state_d = MAU_IDLE;
            MAU_ERR:  state_d = MAU_IDLE;
            default:  state_d = MAU_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == MAU_REQ);
        busy     = (state_q == MAU_REQ);
        mem_we   = (state_q == MAU_REQ) && is_store(op_q);
        done     = (state_q == MAU_DONE) || (state_q == MAU_ERR);
        err      = (state_q == MAU_ERR);
        mem_addr = {addr_q[31:2], 2'b00};
        rdata    = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors for loads, stores,
// alignment errors, timeout and reset during a request.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, start, mem_ack;
    logic [5:0]  op;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_req, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle, then scramble the inputs so latching is exercised.
    task automatic do_start(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        tick();
        start = 1'b0;
        op    = 6'h00;
        addr  = 32'hFFFF_FFFF;
        wdata = 32'h5555_5555;
    endtask

    task automatic run_load(input string tag, input logic [5:0] o, input logic [31:0] a,
                            input logic [31:0] word, input logic [3:0] exp_be,
                            input logic [31:0] exp_rdata);
        mem_rdata = word;
        do_start(o, a, 32'h0);
        chk({tag, ".req"},  mem_req, 1);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".we"},   mem_we, 0);
        chk({tag, ".be"},   mem_be, exp_be);
        chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ".done_early"}, done, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, ".done"},  done, 1);
        chk({tag, ".err"},   err, 0);
        chk({tag, ".req_off"}, mem_req, 0);
        chk({tag, ".rdata"}, rdata, exp_rdata);
        tick();
        chk({tag, ".idle"},  done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; op = 6'h00; addr = 32'h0; wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst.req",   mem_req, 0);
        chk("rst.we",    mem_we, 0);
        chk("rst.busy",  busy, 0);
        chk("rst.done",  done, 0);
        chk("rst.err",   err, 0);
        chk("rst.rdata", rdata, 32'h0);
        rstn = 1'b1;
        tick();

        run_load("lw",  OP_LW,  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        run_load("lb",  OP_LB,  32'h0000_0103, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80);
        run_load("lbu", OP_LBU, 32'h0000_0103, 32'h8011_2233, 4'b1000, 32'h0000_0080);
        run_load("lb1", OP_LB,  32'h0000_0101, 32'h8011_2233, 4'b0010, 32'h0000_0022);
        run_load("lh",  OP_LH,  32'h0000_0102, 32'h8011_2233, 4'b1100, 32'hFFFF_8011);
        run_load("lhu", OP_LHU, 32'h0000_0100, 32'h8011_A233, 4'b0011, 32'h0000_A233);

        // SH with three wait cycles and a start attempt while busy
        mem_rdata = 32'h1111_1111;
        do_start(OP_SH, 32'h0000_0202, 32'h0000_ABCD);
        chk("sh.req",   mem_req, 1);
        chk("sh.we",    mem_we, 1);
        chk("sh.be",    mem_be, 4'b1100);
        chk("sh.wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh.addr",  mem_addr, 32'h0000_0200);
        start = 1'b1; op = OP_LW; addr = 32'h0000_0300; wdata = 32'h0;
        tick();
        start = 1'b0;
        chk("sh.busy_start_addr", mem_addr, 32'h0000_0200);
        chk("sh.busy_start_be",   mem_be, 4'b1100);
        chk("sh.busy_start_we",   mem_we, 1);
        tick();
        chk("sh.wait3_req", mem_req, 1);
        tick();
        chk("sh.wait4_req", mem_req, 1);
        chk("sh.wait4_done", done, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sh.done",  done, 1);
        chk("sh.err",   err, 0);
        chk("sh.rdata_kept", rdata, 32'h0000_A233);
        tick();
        chk("sh.no_relaunch", mem_req, 0);
        chk("sh.idle_done",   done, 0);

        // SB replication
        do_start(OP_SB, 32'h0000_0201, 32'h1234_5677);
        chk("sb.be",    mem_be, 4'b0010);
        chk("sb.wdata", mem_wdata, 32'h7777_7777);
        chk("sb.we",    mem_we, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sb.done", done, 1);
        tick();

        // Misaligned word: straight to ERR, start during ERR ignored
        do_start(OP_LW, 32'h0000_0101, 32'h0);
        chk("mis.req",  mem_req, 0);
        chk("mis.busy", busy, 0);
        chk("mis.done", done, 1);
        chk("mis.err",  err, 1);
        chk("mis.rdata", rdata, 32'h0000_A233);
        start = 1'b1; op = OP_LW; addr = 32'h0000_0400;
        tick();
        start = 1'b0;
        chk("mis.start_ignored_req", mem_req, 0);
        chk("mis.after_done", done, 0);
        tick();

        do_start(OP_LH, 32'h0000_0101, 32'h0);
        chk("mish.err", err, 1);
        chk("mish.req", mem_req, 0);
        tick();

        do_start(6'h00, 32'h0000_0100, 32'h0);
        chk("ill.err",  err, 1);
        chk("ill.done", done, 1);
        tick();

        // Timeout with TIMEOUT_CYCLES=4, then a late ack
        mem_rdata = 32'hCAFE_F00D;
        do_start(OP_LW, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.req%0d", i), mem_req, 1);
            chk($sformatf("to.done%0d", i), done, 0);
            tick();
        end
        chk("to.req_off", mem_req, 0);
        chk("to.done",    done, 1);
        chk("to.err",     err, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("to.late_done",  done, 0);
        chk("to.late_req",   mem_req, 0);
        chk("to.late_rdata", rdata, 32'h0000_A233);

        // Reset in the second REQ cycle
        do_start(OP_LW, 32'h0000_0600, 32'h0);
        chk("rq.req1", mem_req, 1);
        tick();
        chk("rq.req2", mem_req, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rq.req_drop", mem_req, 0);
        chk("rq.busy",     busy, 0);
        chk("rq.done",     done, 0);
        chk("rq.rdata",    rdata, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rq.late_done", done, 0);
        chk("rq.late_req",  mem_req, 0);
        tick();

        run_load("lw2", OP_LW, 32'h0000_0700, 32'h0102_0304, 4'b1111, 32'h0102_0304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
